// File: rtl/systolic_feeder_if.sv
// Job control, operand beats and skewed array-edge outputs of the systolic feeder.
interface systolic_feeder_if #(
   parameter int N  = 4,
   parameter int DW = 32,
   parameter int KW = 16
);
   logic            start;
   logic [KW-1:0]   k_len;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] a_vec;
   logic [N*DW-1:0] b_vec;
   logic [N*DW-1:0] west_out;
   logic [N*DW-1:0] north_out;
   logic            busy;
   logic            done;

   modport master (
      output start, k_len, in_valid, a_vec, b_vec,
      input  in_ready, west_out, north_out, busy, done
   );

   modport slave (
      input  start, k_len, in_valid, a_vec, b_vec,
      output in_ready, west_out, north_out, busy, done
   );
endinterface

// File: rtl/systolic_feeder.sv
// Skews A columns / B rows onto the west/north edges of an NxN systolic array; lane i latency 1+i cycles.
// Beats accepted only in STREAM (registered in_ready); bubbles and flush push zeros; done 2N cycles after last beat.
module systolic_feeder #(
   parameter int N  = 4,
   parameter int DW = 32,
   parameter int KW = 16
) (
   input logic              clk,
   input logic              rst,
   systolic_feeder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

   state_t          state;
   logic [KW-1:0]   k_reg;
   logic [KW-1:0]   cnt;
   logic            ready_q;
   logic            busy_q;
   logic            done_q;
   logic            hs;
   logic [N*DW-1:0] a_push;
   logic [N*DW-1:0] b_push;

   assign hs     = bus.in_valid && ready_q;
   assign a_push = hs ? bus.a_vec : '0;
   assign b_push = hs ? bus.b_vec : '0;

   assign bus.in_ready = ready_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

   // cnt counts accepted beats in STREAM, then counts down the 2N-1 flush cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         k_reg   <= '0;
         cnt     <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  busy_q <= 1'b1;
                  if (bus.k_len != '0) begin
                     state   <= STREAM;
                     k_reg   <= bus.k_len;
                     cnt     <= '0;
                     ready_q <= 1'b1;
                  end else begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (hs) begin
                  if (cnt + KW'(1) == k_reg) begin
                     state   <= FLUSH;
                     cnt     <= KW'(2 * N - 2);
                     ready_q <= 1'b0;
                  end else begin
                     cnt <= cnt + KW'(1);
                  end
               end
            end
            FLUSH: begin
               if (cnt == '0) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end else begin
                  cnt <= cnt - KW'(1);
               end
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Lane i: i delay registers plus the shared output stage, all shifting every cycle.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DW-1:0] w_pipe [i+1];
      logic [DW-1:0] n_pipe [i+1];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int s = 0; s <= i; s++) begin
               w_pipe[s] <= '0;
               n_pipe[s] <= '0;
            end
         end else begin
            w_pipe[0] <= a_push[i*DW +: DW];
            n_pipe[0] <= b_push[i*DW +: DW];
            for (int s = 1; s <= i; s++) begin
               w_pipe[s] <= w_pipe[s-1];
               n_pipe[s] <= n_pipe[s-1];
            end
         end
      end

      assign bus.west_out[i*DW +: DW]  = w_pipe[i];
      assign bus.north_out[i*DW +: DW] = n_pipe[i];
   end
endmodule
